// File: rtl/alu_issue.sv
// Issue stage in front of a combinational ALU. Commands are queued in a small FIFO,
// issued one at a time, and each result is held until the downstream side accepts it.
module alu_issue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [2:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_y,
  input  logic        alu_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_y,
  output logic        out_cout,
  output logic [2:0]  out_op
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  state_t        state;
  logic [34:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          not_empty;
  logic          push;
  logic          pop;

  // in_ready depends only on occupancy, so a full FIFO refuses a push even when it pops
  assign not_empty = (count != '0);
  assign in_ready  = rst_n && (count < FULL_COUNT);
  assign push      = in_valid && in_ready;

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = not_empty;
      HOLD:    pop = out_valid && out_ready && not_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_op, in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  // Every pop loads the ALU operands; the state case only decides where the FSM goes next
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_cout  <= 1'b0;
      out_op    <= '0;
    end else begin
      if (pop) begin
        {alu_op, alu_a, alu_b} <= mem[rd_ptr];
      end
      case (state)
        IDLE: begin
          if (pop) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          out_y     <= alu_y;
          out_cout  <= alu_cout;
          out_op    <= alu_op;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= pop ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: a stub ALU drives alu_y/alu_cout, and a command
// queue scoreboard predicts every accepted result in push order.
module tb_alu_issue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_y;
  logic        alu_cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_y;
  logic        out_cout;
  logic [2:0]  out_op;

  int n_checks = 0;
  int n_errors = 0;
  int n_results = 0;
  int n_sent = 0;
  logic rand_ready = 1'b0;
  logic [34:0] exp_q[$];

  logic        prev_hold = 1'b0;
  logic [19:0] prev_out = '0;

  alu_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_cout(out_cout), .out_op(out_op)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {cout, y}
  function automatic logic [16:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {1'b0, a} - {1'b0, b};
      3'b010:  return {a, 1'b0};
      3'b011:  return {1'b0, b} - {1'b0, a};
      3'b100:  return {1'b0, a & b};
      3'b101:  return {1'b0, a | b};
      3'b110:  return {1'b0, a ^ b};
      default: return {1'b0, ~a};
    endcase
  endfunction

  assign {alu_cout, alu_y} = alu_ref(alu_op, alu_a, alu_b);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: record accepted commands, match handshaken results, and check held results stay put
  always @(negedge clk) begin
    logic [34:0] cmd;
    logic [16:0] r;
    if (prev_hold) begin
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_stable", 32'({out_cout, out_op, out_y}), 32'(prev_out));
    end
    prev_hold = (rst_n === 1'b1) && (out_valid === 1'b1) && (out_ready === 1'b0);
    prev_out  = {out_cout, out_op, out_y};
    if (rst_n !== 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 32'd1, 32'd0);
        end else begin
          cmd = exp_q.pop_front();
          r = alu_ref(cmd[34:32], cmd[31:16], cmd[15:0]);
          checkOutput("out_y", 32'(out_y), 32'(r[15:0]));
          checkOutput("out_cout", 32'(out_cout), 32'(r[16]));
          checkOutput("out_op", 32'(out_op), 32'(cmd[34:32]));
          n_results++;
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back({in_op, in_a, in_b});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic accepted;
    accepted = 1'b0;
    applyStimulus(1'b1, op, a, b);
    for (int i = 0; i < 200; i++) begin
      if (in_ready === 1'b1) begin
        accepted = 1'b1;
        step();
        break;
      end
      step();
    end
    if (!accepted) checkOutput("send_timeout", 32'd0, 32'd1);
    else n_sent++;
    applyStimulus(1'b0, 3'd0, 16'd0, 16'd0);
  endtask

  task automatic waitValid(input string tag);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    if (out_valid !== 1'b1) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid !== 1'b0) && k < 500) begin
      step();
      k++;
    end
    if (exp_q.size() != 0 || out_valid !== 1'b0) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [16:0] r0;
    logic [16:0] r1;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [15:0] a1;
    logic [15:0] b1;

    // Reset held for two edges
    rst_n = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'd0, 16'd0);
    step();
    step();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_alu", 32'({alu_op, alu_a, alu_b} != '0), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out", 32'({out_cout, out_op, out_y}), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", 32'(in_ready), 32'd1);

    // Single add with exact latency
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'b000, 16'h8F54, 16'h79F8);
    step();
    n_sent++;
    applyStimulus(1'b0, 3'd0, 16'd0, 16'd0);
    checkOutput("lat_n_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("lat_alu_a", 32'(alu_a), 32'h8F54);
    checkOutput("lat_alu_b", 32'(alu_b), 32'h79F8);
    checkOutput("lat_alu_op", 32'(alu_op), 32'd0);
    checkOutput("lat_n1_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("lat_n2_valid", 32'(out_valid), 32'd1);
    checkOutput("lat_out_y", 32'(out_y), 32'h094C);
    checkOutput("lat_out_cout", 32'(out_cout), 32'd1);
    checkOutput("lat_out_op", 32'(out_op), 32'd0);
    step();
    checkOutput("lat_done_valid", 32'(out_valid), 32'd0);

    // Fill with the output stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(3'(i), 16'($urandom), 16'($urandom));
    end
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 3'b111, 16'hDEAD, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("full_blocked", 32'(in_ready), 32'd0);
    end
    applyStimulus(1'b0, 3'd0, 16'd0, 16'd0);
    out_ready = 1'b1;
    waitDrain();

    // Backpressure for 10 cycles, then a second result two cycles after release
    out_ready = 1'b0;
    a0 = 16'($urandom);
    b0 = 16'($urandom);
    a1 = 16'($urandom);
    b1 = 16'($urandom);
    r0 = alu_ref(3'b001, a0, b0);
    r1 = alu_ref(3'b110, a1, b1);
    send(3'b001, a0, b0);
    waitValid("bp_wait_valid");
    send(3'b110, a1, b1);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_y", 32'(out_y), 32'(r0[15:0]));
    end
    out_ready = 1'b1;
    step();
    checkOutput("bp_gap_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("bp_next_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_next_y", 32'(out_y), 32'(r1[15:0]));
    checkOutput("bp_next_cout", 32'(out_cout), 32'(r1[16]));
    waitDrain();

    // Ordered stream cycling every opcode, then random traffic, random out_ready
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(3'(i % 8), 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 20; i++) begin
      send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("result_count", 32'(n_results), 32'(n_sent));

    // Reset while holding a result with three commands queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(3'b000, 16'($urandom), 16'($urandom));
    end
    waitValid("mid_wait_valid");
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
    end
    send(3'b000, 16'h1234, 16'h4321);
    step();
    checkOutput("post_rst_n1", 32'(out_valid), 32'd0);
    step();
    checkOutput("post_rst_new_valid", 32'(out_valid), 32'd1);
    checkOutput("post_rst_new_y", 32'(out_y), 32'h5555);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth in entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; one clock, no other clock domains.
REQ-004 in_valid  input  1  upstream command valid.
REQ-005 in_ready  output  1  FIFO can accept command.
REQ-006 in_op  input  3  ALU opcode (000-011 arithmetic, 100-111 logic).
REQ-007 in_a, in_b  input  16 each  operands.
REQ-008 alu_op  output  3  registered opcode driven to ALU op.
REQ-009 alu_a, alu_b  output  16 each  registered operands driven to ALU a/b.
REQ-010 alu_y  input  16  ALU result.
REQ-011 alu_cout  input  1  ALU carry-out.
REQ-012 out_valid  output  1  captured result valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_y  output  16  captured result.
REQ-015 out_cout  output  1  captured carry.
REQ-016 out_op  output  3  opcode that produced out_y.

Function
REQ-017 Command FIFO of DEPTH entries, {op,a,b} 35 bits; push when in_valid && in_ready; in_ready = rst_n && (count < DEPTH).
REQ-018 Read/write pointers wrap modulo DEPTH; count range 0..DEPTH; push+pop same cycle leaves count unchanged.
REQ-019 Full: in_ready low; no push even if a pop occurs the same cycle; in_valid ignored.
REQ-020 Empty: no pop; alu_* outputs hold last values.
REQ-021 FSM states IDLE, ISSUE, HOLD.
REQ-022 IDLE: FIFO non-empty -> pop head into alu_op/alu_a/alu_b, go ISSUE; else stay.
REQ-023 ISSUE: capture alu_y, alu_cout, alu_op into out_y, out_cout, out_op; set out_valid; go HOLD.
REQ-024 HOLD: out_valid high, out_* stable until out_ready; on out_valid && out_ready: FIFO non-empty -> pop next into alu_*, clear out_valid, go ISSUE; else clear out_valid, go IDLE.
REQ-025 Latency: command pushed at edge N into empty FIFO with FSM in IDLE -> alu_* loaded edge N+1 -> out_valid high after edge N+2.
REQ-026 Throughput with out_ready held high: one result per 2 cycles.
REQ-027 Commands complete strictly in push order; none dropped or duplicated.
REQ-028 alu_* change only on a pop; out_* change only in ISSUE or reset.
REQ-029 Block performs no arithmetic; out_y/out_cout are exact copies of alu_y/alu_cout sampled in ISSUE.

Reset
REQ-030 rst_n low at a rising edge: state IDLE, pointers and count 0, alu_op/alu_a/alu_b 0, out_valid 0, out_y 0, out_cout 0, out_op 0; in_ready 0 while rst_n low.
REQ-031 Reset mid-operation (ISSUE or HOLD, FIFO non-empty) discards all queued commands and any pending result; no out_valid in the cycle after release.
REQ-032 First push accepted on first edge with rst_n high.

Verification (bench stub models ALU op 000 as y=a+b, cout=carry)
REQ-033 Reset: hold rst_n low 2 cycles -> all outputs 0, in_ready 0; release -> in_ready 1.
REQ-034 Single op: push {000,8F54,79F8}, out_ready=1 -> alu_a=8F54, alu_b=79F8 after 1 edge; out_y=094C, out_cout=1, out_op=000 with out_valid after 2 edges.
REQ-035 Fill: out_ready=0, push 5 commands -> first accepted, then FIFO holds DEPTH=4 more only after head pops; in_ready low when count=4; no loss.
REQ-036 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_valid and out_y stable; then out_ready=1 -> next result 2 cycles later.
REQ-037 Order/wrap: stream 10 commands op 000..111 cycling, random out_ready -> 10 results in push order, pointers wrap correctly.
REQ-038 Mid-reset: reset during HOLD with 3 queued -> after release, no out_valid until a new push.
